branch_update_queue: RTL and testbench

//  Update stage behind branch_history. Records each prediction made at fetch (pc, BHR snapshot,
//  2-bit PHT counter) in an in-order queue. When execute resolves the oldest branch, it computes
//  the new counter and the new BHR, and issues one write to the BHT and one to the PHT.

---
 rtl/branch_update_queue_pkg.sv | 45 ++++
 rtl/branch_update_queue_if.sv | 35 +++
 rtl/branch_update_queue_fifo.sv | 59 +++++
 rtl/branch_update_queue.sv | 87 ++++++++
 tb/tb_branch_update_queue.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/branch_update_queue_pkg.sv
// Shared widths, the in-flight branch record and the index/counter helpers
// used by the branch update stage.
package branch_update_queue_pkg;

    localparam int DEPTH     = 8;
    localparam int BHR_W     = 4;
    localparam int BHT_IDX_W = 4;
    localparam int PHT_IDX_W = 3 + BHR_W;
    localparam int PTR_W     = $clog2(DEPTH);
    localparam int OCC_W     = PTR_W + 1;

    typedef struct packed {
        logic [31:0]      pc;
        logic [BHR_W-1:0] bhr;
        logic [1:0]       state;
    } rec_t;

    localparam int REC_W = $bits(rec_t);

    // XOR-fold every pc nibble down to one BHT index.
    function automatic logic [BHT_IDX_W-1:0] bht_hash(input logic [31:0] pc);
        logic [BHT_IDX_W-1:0] h;
        h = '0;
        for (int i = 0; i < 32 / BHT_IDX_W; i++) begin
            h = h ^ pc[i*BHT_IDX_W +: BHT_IDX_W];
        end
        return h;
    endfunction

    function automatic logic [PHT_IDX_W-1:0] pht_index(input logic [2:0]       pc_lo,
                                                        input logic [BHR_W-1:0] bhr);
        return {pc_lo, bhr};
    endfunction

    function automatic logic [1:0] sat_update(input logic [1:0] state, input logic taken);
        logic [1:0] nxt;
        if (taken) begin
            nxt = (state == 2'b11) ? 2'b11 : state + 2'd1;
        end else begin
            nxt = (state == 2'b00) ? 2'b00 : state - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/branch_update_queue_if.sv
// Prediction, resolution and BHT/PHT write signals of the branch update stage.
// The slave modport is the queue itself, the master modport is its environment.
interface branch_update_queue_if;
    import branch_update_queue_pkg::*;

    logic                 pred_valid;
    logic                 pred_ready;
    logic [31:0]          pred_pc;
    logic [BHR_W-1:0]     pred_bhr;
    logic [1:0]           pred_state;
    logic                 res_valid;
    logic                 res_taken;
    logic                 res_err;
    logic                 mispredict;
    logic                 bht_we;
    logic [BHT_IDX_W-1:0] bht_waddr;
    logic [BHR_W-1:0]     bht_wdata;
    logic                 pht_we;
    logic [PHT_IDX_W-1:0] pht_waddr;
    logic [1:0]           pht_wdata;
    logic [OCC_W-1:0]     occupancy;

    modport slave (
        input  pred_valid, pred_pc, pred_bhr, pred_state, res_valid, res_taken,
        output pred_ready, res_err, mispredict, bht_we, bht_waddr, bht_wdata,
               pht_we, pht_waddr, pht_wdata, occupancy
    );

    modport master (
        output pred_valid, pred_pc, pred_bhr, pred_state, res_valid, res_taken,
        input  pred_ready, res_err, mispredict, bht_we, bht_waddr, bht_wdata,
               pht_we, pht_waddr, pht_wdata, occupancy
    );

endinterface

// File: rtl/branch_update_queue_fifo.sv
// Generic synchronous FIFO with push/pop/clear; head visible combinationally, count registered.
// Pushes when full and pops when empty are ignored; clear wins over a same-cycle push.
module branch_update_queue_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_dat,
    input  logic                       pop,
    input  logic                       clear,
    output logic [WIDTH-1:0]           head_dat,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    assign full     = (cnt == (AW+1)'(DEPTH));
    assign empty    = (cnt == '0);
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign head_dat = mem[rd_ptr];
    assign count    = cnt;

    // Pointers are a power-of-two width, so increment wraps modulo DEPTH.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/branch_update_queue.sv
// In-order queue of fetch predictions; resolving the head issues one BHT and one PHT write.
// Writes/flags registered (1 cycle after resolve); pred_ready low when full, mispredict flushes all.
module branch_update_queue
    import branch_update_queue_pkg::*;
(
    input  logic                 clk,
    input  logic                 resetn,
    branch_update_queue_if.slave bus
);
    rec_t             push_rec;
    rec_t             head;
    logic             full;
    logic             empty;
    logic [OCC_W-1:0] count;
    logic             pop;
    logic             wrong_path;

    logic                 bht_we_q;
    logic [BHT_IDX_W-1:0] bht_waddr_q;
    logic [BHR_W-1:0]     bht_wdata_q;
    logic                 pht_we_q;
    logic [PHT_IDX_W-1:0] pht_waddr_q;
    logic [1:0]           pht_wdata_q;
    logic                 mispredict_q;
    logic                 res_err_q;

    assign push_rec.pc    = bus.pred_pc;
    assign push_rec.bhr   = bus.pred_bhr;
    assign push_rec.state = bus.pred_state;

    assign pop        = bus.res_valid & ~empty;
    assign wrong_path = pop & (bus.res_taken != head.state[1]);

    // A mispredict clears the whole queue, including any push accepted this cycle.
    branch_update_queue_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .resetn   (resetn),
        .push     (bus.pred_valid),
        .push_dat (push_rec),
        .pop      (pop),
        .clear    (wrong_path),
        .head_dat (head),
        .full     (full),
        .empty    (empty),
        .count    (count)
    );

    // Updates are built from the recorded bhr snapshot, never from live BHT contents.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bht_we_q     <= 1'b0;
            bht_waddr_q  <= '0;
            bht_wdata_q  <= '0;
            pht_we_q     <= 1'b0;
            pht_waddr_q  <= '0;
            pht_wdata_q  <= '0;
            mispredict_q <= 1'b0;
            res_err_q    <= 1'b0;
        end else begin
            bht_we_q     <= pop;
            pht_we_q     <= pop;
            mispredict_q <= wrong_path;
            res_err_q    <= bus.res_valid & empty;
            if (pop) begin
                bht_waddr_q <= bht_hash(head.pc);
                bht_wdata_q <= {head.bhr[BHR_W-2:0], bus.res_taken};
                pht_waddr_q <= pht_index(head.pc[2:0], head.bhr);
                pht_wdata_q <= sat_update(head.state, bus.res_taken);
            end
        end
    end

    assign bus.pred_ready = ~full;
    assign bus.occupancy  = count;
    assign bus.bht_we     = bht_we_q;
    assign bus.bht_waddr  = bht_waddr_q;
    assign bus.bht_wdata  = bht_wdata_q;
    assign bus.pht_we     = pht_we_q;
    assign bus.pht_waddr  = pht_waddr_q;
    assign bus.pht_wdata  = pht_wdata_q;
    assign bus.mispredict = mispredict_q;
    assign bus.res_err    = res_err_q;

endmodule

// File: tb/tb_branch_update_queue.sv
// Scenario bench for branch_update_queue: a record model feeds a queue of expected
// BHT/PHT writes that a monitor pops whenever the design issues a write.
module tb_branch_update_queue;
    import branch_update_queue_pkg::*;

    typedef struct packed {
        logic [3:0] bht_a;
        logic [3:0] bht_d;
        logic [6:0] pht_a;
        logic [1:0] pht_d;
        logic       mis;
    } exp_t;

    logic clk = 1'b0;
    logic resetn;
    int   errors = 0;
    int   checks = 0;
    bit   last_err;
    rec_t mq[$];
    exp_t exp_q[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    branch_update_queue_if bus ();

    branch_update_queue dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    function automatic logic [3:0] m_hash(input logic [31:0] pc);
        return pc[31:28] ^ pc[27:24] ^ pc[23:20] ^ pc[19:16] ^
               pc[15:12] ^ pc[11:8]  ^ pc[7:4]   ^ pc[3:0];
    endfunction

    function automatic logic [1:0] m_counter(input logic [1:0] st, input bit taken);
        case ({taken, st})
            3'b1_00: return 2'b01;
            3'b1_01: return 2'b10;
            3'b1_10: return 2'b11;
            3'b1_11: return 2'b11;
            3'b0_00: return 2'b00;
            3'b0_01: return 2'b00;
            3'b0_10: return 2'b01;
            default: return 2'b10;
        endcase
    endfunction

    // Drive one cycle of stimulus and advance the model; returns 2 time units after the edge.
    task automatic cycle(input bit pv, input logic [31:0] pc, input logic [3:0] bhr,
                         input logic [1:0] st, input bit rv, input bit rt);
        rec_t r;
        exp_t e;
        bit   push_ok, pop_ok, flush;
        push_ok  = pv && (mq.size() < DEPTH);
        pop_ok   = rv && (mq.size() != 0);
        last_err = rv && (mq.size() == 0);
        flush    = 1'b0;
        bus.pred_valid = pv;  bus.pred_pc = pc;  bus.pred_bhr = bhr;  bus.pred_state = st;
        bus.res_valid  = rv;  bus.res_taken = rt;
        if (pop_ok) begin
            r       = mq.pop_front();
            e.bht_a = m_hash(r.pc);
            e.bht_d = {r.bhr[2:0], rt};
            e.pht_a = {r.pc[2:0], r.bhr};
            e.pht_d = m_counter(r.state, rt);
            e.mis   = (rt != r.state[1]);
            flush   = e.mis;
            exp_q.push_back(e);
        end
        if (push_ok) mq.push_back('{pc: pc, bhr: bhr, state: st});
        if (flush) mq.delete();
        @(posedge clk);
        #2;
    endtask

    always @(negedge clk) begin
        if (resetn === 1'b1) begin
            checks++;
            if (bus.bht_we !== bus.pht_we) begin
                errors++;
                $display("FAIL strobe_pair bht_we=%b pht_we=%b", bus.bht_we, bus.pht_we);
            end
            if (bus.bht_we === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write bht_waddr=%h pht_waddr=%h required none",
                             bus.bht_waddr, bus.pht_waddr);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (bus.bht_waddr !== mon_e.bht_a || bus.bht_wdata !== mon_e.bht_d ||
                        bus.pht_waddr !== mon_e.pht_a || bus.pht_wdata !== mon_e.pht_d ||
                        bus.mispredict !== mon_e.mis) begin
                        errors++;
                        $display("FAIL write_record got bht %h/%b pht %b/%b mis %b, required bht %h/%b pht %b/%b mis %b",
                                 bus.bht_waddr, bus.bht_wdata, bus.pht_waddr, bus.pht_wdata, bus.mispredict,
                                 mon_e.bht_a, mon_e.bht_d, mon_e.pht_a, mon_e.pht_d, mon_e.mis);
                    end
                end
            end else if (bus.mispredict === 1'b1) begin
                checks++;
                errors++;
                $display("FAIL stray_mispredict mispredict=1 without a write, required 0");
            end
        end
    end

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #2;
        checks++; if (bus.occupancy !== 4'd0) begin errors++; $display("FAIL reset_occ got %0d required 0", bus.occupancy); end
        checks++; if (bus.pred_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b required 1", bus.pred_ready); end
        checks++; if ({bus.bht_we, bus.pht_we, bus.res_err, bus.mispredict} !== 4'b0) begin errors++; $display("FAIL reset_strobes got %b required 0000", {bus.bht_we, bus.pht_we, bus.res_err, bus.mispredict}); end
        checks++; if ({bus.bht_waddr, bus.bht_wdata, bus.pht_waddr, bus.pht_wdata} !== 17'd0) begin errors++; $display("FAIL reset_wdata got %h required 0", {bus.bht_waddr, bus.bht_wdata, bus.pht_waddr, bus.pht_wdata}); end
        resetn = 1'b1;
        for (int i = 0; i < 3; i++) cycle(1, 32'h40 + 32'(i), 4'(i), 2'b11, 0, 0);
        checks++; if (bus.occupancy !== 4'd3) begin errors++; $display("FAIL pre_reset_occ got %0d required 3", bus.occupancy); end
        resetn = 1'b0;
        mq.delete();
        exp_q.delete();
        #1;
        checks++; if (bus.occupancy !== 4'd0) begin errors++; $display("FAIL midreset_occ got %0d required 0", bus.occupancy); end
        checks++; if (bus.pred_ready !== 1'b1) begin errors++; $display("FAIL midreset_ready got %b required 1", bus.pred_ready); end
        @(negedge clk);
        resetn = 1'b1;
        cycle(0, 0, 0, 0, 1, 1);
        checks++; if (bus.res_err !== 1'b1 || bus.bht_we !== 1'b0) begin errors++; $display("FAIL after_reset_resolve res_err=%b bht_we=%b required 1 0", bus.res_err, bus.bht_we); end
        cycle(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_basic();
        cycle(1, 32'h0000_1234, 4'b0101, 2'b10, 0, 0);
        checks++; if (bus.occupancy !== 4'd1) begin errors++; $display("FAIL basic_push_occ got %0d required 1", bus.occupancy); end
        cycle(0, 0, 0, 0, 1, 1);
        checks++; if (bus.bht_waddr !== 4'h4) begin errors++; $display("FAIL basic_bht_waddr got %h required 4", bus.bht_waddr); end
        checks++; if (bus.bht_wdata !== 4'b1011) begin errors++; $display("FAIL basic_bht_wdata got %b required 1011", bus.bht_wdata); end
        checks++; if (bus.pht_waddr !== 7'b100_0101) begin errors++; $display("FAIL basic_pht_waddr got %b required 1000101", bus.pht_waddr); end
        checks++; if (bus.pht_wdata !== 2'b11 || bus.mispredict !== 1'b0) begin errors++; $display("FAIL basic_pht_wdata got %b mis %b required 11 0", bus.pht_wdata, bus.mispredict); end
        checks++; if (bus.occupancy !== 4'd0) begin errors++; $display("FAIL basic_pop_occ got %0d required 0", bus.occupancy); end
        cycle(0, 0, 0, 0, 0, 0);
        checks++; if (bus.bht_we !== 1'b0) begin errors++; $display("FAIL basic_one_pulse bht_we=%b required 0", bus.bht_we); end
    endtask

    task automatic test_saturation();
        cycle(1, 32'hDEAD_BEEF, 4'b1100, 2'b11, 0, 0);
        cycle(1, 32'h0BAD_F00D, 4'b0011, 2'b00, 0, 0);
        cycle(0, 0, 0, 0, 1, 1);
        checks++; if (bus.pht_wdata !== 2'b11) begin errors++; $display("FAIL sat_high got %b required 11", bus.pht_wdata); end
        cycle(0, 0, 0, 0, 1, 0);
        checks++; if (bus.pht_wdata !== 2'b00) begin errors++; $display("FAIL sat_low got %b required 00", bus.pht_wdata); end
        cycle(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_flush();
        cycle(1, 32'h1000, 4'b0001, 2'b01, 0, 0);
        cycle(1, 32'h1004, 4'b0010, 2'b11, 0, 0);
        cycle(1, 32'h1008, 4'b0011, 2'b11, 0, 0);
        cycle(0, 0, 0, 0, 1, 1);
        checks++; if (bus.mispredict !== 1'b1 || bus.bht_we !== 1'b1) begin errors++; $display("FAIL flush_mis mis=%b we=%b required 1 1", bus.mispredict, bus.bht_we); end
        checks++; if (bus.occupancy !== 4'd0) begin errors++; $display("FAIL flush_occ got %0d required 0", bus.occupancy); end
        repeat (3) cycle(0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 1, 1);
        checks++; if (bus.res_err !== 1'b1) begin errors++; $display("FAIL flush_dropped res_err=%b required 1", bus.res_err); end
        cycle(1, 32'h2000, 4'b1111, 2'b01, 0, 0);
        cycle(1, 32'h2004, 4'b1110, 2'b10, 0, 0);
        cycle(1, 32'h2008, 4'b1101, 2'b10, 1, 1);
        checks++; if (bus.mispredict !== 1'b1 || bus.occupancy !== 4'd0) begin errors++; $display("FAIL flush_same_cycle mis=%b occ=%0d required 1 0", bus.mispredict, bus.occupancy); end
        cycle(0, 0, 0, 0, 0, 0);
        @(negedge clk); #1;
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL flush_pending got %0d writes outstanding required 0", exp_q.size()); end
    endtask

    task automatic test_full();
        for (int i = 0; i < 8; i++) cycle(1, 32'h3000 + 32'(i * 36), 4'(i + 3), 2'(i), 0, 0);
        checks++; if (bus.occupancy !== 4'd8 || bus.pred_ready !== 1'b0) begin errors++; $display("FAIL full_state occ=%0d ready=%b required 8 0", bus.occupancy, bus.pred_ready); end
        cycle(1, 32'h3FFC, 4'b1010, 2'b11, 0, 0);
        checks++; if (bus.occupancy !== 4'd8) begin errors++; $display("FAIL full_push_ignored occ=%0d required 8", bus.occupancy); end
        cycle(1, 32'h3FF8, 4'b1001, 2'b11, 1, mq[0].state[1]);
        checks++; if (bus.occupancy !== 4'd7 || bus.mispredict !== 1'b0) begin errors++; $display("FAIL full_push_pop occ=%0d mis=%b required 7 0", bus.occupancy, bus.mispredict); end
        cycle(1, 32'h3FF4, 4'b0110, 2'b10, 1, mq[0].state[1]);
        checks++; if (bus.occupancy !== 4'd7) begin errors++; $display("FAIL push_pop_steady occ=%0d required 7", bus.occupancy); end
        cycle(1, 32'h3FF0, 4'b0111, 2'b00, 0, 0);
        checks++; if (bus.occupancy !== 4'd8) begin errors++; $display("FAIL refill occ=%0d required 8", bus.occupancy); end
        for (int i = 0; i < 8; i++) cycle(0, 0, 0, 0, 1, mq[0].state[1]);
        checks++; if (bus.occupancy !== 4'd0 || bus.pred_ready !== 1'b1) begin errors++; $display("FAIL drain occ=%0d ready=%b required 0 1", bus.occupancy, bus.pred_ready); end
        cycle(0, 0, 0, 0, 0, 0);
        @(negedge clk); #1;
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL drain_pending got %0d writes outstanding required 0", exp_q.size()); end
    endtask

    task automatic test_empty();
        cycle(0, 0, 0, 0, 1, 0);
        checks++; if (bus.res_err !== 1'b1) begin errors++; $display("FAIL empty_err got %b required 1", bus.res_err); end
        checks++; if (bus.bht_we !== 1'b0 || bus.pht_we !== 1'b0) begin errors++; $display("FAIL empty_we bht=%b pht=%b required 0 0", bus.bht_we, bus.pht_we); end
        cycle(0, 0, 0, 0, 0, 0);
        checks++; if (bus.res_err !== 1'b0) begin errors++; $display("FAIL empty_err_pulse got %b required 0", bus.res_err); end
    endtask

    task automatic test_back_to_back();
        bit pv, rv, rt;
        for (int n = 0; n < 300; n++) begin
            pv = ($urandom_range(0, 2) != 0);
            rv = ($urandom_range(0, 1) != 0);
            if (mq.size() != 0 && $urandom_range(0, 7) != 0) rt = mq[0].state[1];
            else rt = 1'($urandom_range(0, 1));
            cycle(pv, $urandom, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), rv, rt);
            checks++; if (bus.occupancy !== OCC_W'(mq.size())) begin errors++; $display("FAIL b2b_occ cycle %0d got %0d required %0d", n, bus.occupancy, mq.size()); end
            checks++; if (bus.pred_ready !== (mq.size() < DEPTH)) begin errors++; $display("FAIL b2b_ready cycle %0d got %b required %b", n, bus.pred_ready, mq.size() < DEPTH); end
            checks++; if (bus.res_err !== last_err) begin errors++; $display("FAIL b2b_err cycle %0d got %b required %b", n, bus.res_err, last_err); end
        end
        cycle(0, 0, 0, 0, 0, 0);
        @(negedge clk); #1;
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_pending got %0d writes outstanding required 0", exp_q.size()); end
    endtask

    initial begin
        resetn = 1'b0;
        bus.pred_valid = 1'b0;  bus.pred_pc = '0;  bus.pred_bhr = '0;  bus.pred_state = '0;
        bus.res_valid  = 1'b0;  bus.res_taken = 1'b0;
        test_reset();
        test_basic();
        test_saturation();
        test_flush();
        test_full();
        test_empty();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
